// File: rtl/dpll_pkg.sv
// Shared encodings and helpers for the DPLL acquisition/tracking sequencer.
package dpll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COARSE = 2'd1,
      ST_FINE   = 2'd2,
      ST_LOCKED = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_e;

   // Mid-scale DCO code for a word of width w: only the MSB set.
   function automatic logic [31:0] mid_code(input int unsigned w);
      return 32'd1 << (w - 32'd1);
   endfunction

   // Both or neither PFD flags set means the detector gave no usable decision.
   function automatic dir_e decode_dir(input logic up, input logic dn);
      dir_e d;
      if (up && !dn) begin
         d = DIR_UP;
      end else if (dn && !up) begin
         d = DIR_DN;
      end else begin
         d = DIR_NONE;
      end
      return d;
   endfunction

endpackage

// File: rtl/dpll_sat_updn.sv
// Saturating up/down register with parallel load; holds the DCO control word.
module dpll_sat_updn
   import dpll_pkg::*;
#(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         cdn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Load wins over a step; steps stop at the rails instead of wrapping.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end else if (dec && (q_q != {W{1'b0}})) begin
         q_d = q_q - W'(1);
      end else begin
         q_d = q_q;
      end
   end

   // Code register.
   always_ff @(posedge clk or negedge cdn) begin
      if (!cdn) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/dpll_lock_ctrl.sv
// DPLL sequencer: SAR coarse search, +/-1 fine tracking, lock detect and re-acquire.
module dpll_lock_ctrl
   import dpll_pkg::*;
#(
   parameter int CODE_W     = 8,
   parameter int SETTLE     = 2,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_RUN = 4
) (
   input  logic              clk,
   input  logic              cdn,
   input  logic              en,
   input  logic              up,
   input  logic              dn,
   input  logic              sample_vld,
   output logic [CODE_W-1:0] dco_code,
   output logic              locked,
   output logic [1:0]        state
);

   localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int RW = $clog2(UNLOCK_RUN + 1);
   localparam logic [CODE_W-1:0] MID       = CODE_W'(mid_code(CODE_W));
   localparam logic [BW-1:0]     BIT_TOP   = BW'(CODE_W - 1);
   localparam logic [SW-1:0]     SETTLE_LIM = SW'(SETTLE);
   localparam logic [GW-1:0]     GOOD_LIM  = GW'(LOCK_CNT);
   localparam logic [RW-1:0]     RUN_LIM   = RW'(UNLOCK_RUN);

   state_e             state_q, state_d;
   dir_e               last_q, last_d;
   logic [BW-1:0]      bit_q, bit_d;
   logic [SW-1:0]      settle_q, settle_d;
   logic [GW-1:0]      good_q, good_d;
   logic [RW-1:0]      run_q, run_d;
   logic               locked_q, locked_d;

   dir_e               dir_s;
   logic [CODE_W-1:0]  code_s, trial_s, ld_val_s;
   logic [RW-1:0]      run_next_s;
   logic [GW-1:0]      good_next_s;
   logic               ld_s, inc_s, dec_s;

   // Next-state, counters and code-register controls.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      bit_d       = bit_q;
      settle_d    = settle_q;
      good_d      = good_q;
      run_d       = run_q;
      locked_d    = locked_q;
      ld_s        = 1'b0;
      ld_val_s    = code_s;
      inc_s       = 1'b0;
      dec_s       = 1'b0;
      dir_s       = decode_dir(up, dn);
      good_next_s = good_q;

      // SAR trial: drop the bit under test on DN, arm the next lower bit.
      trial_s = code_s;
      if (dir_s == DIR_DN) begin
         trial_s[bit_q] = 1'b0;
      end else begin
         trial_s[bit_q] = code_s[bit_q];
      end
      if (bit_q != {BW{1'b0}}) begin
         trial_s[bit_q - BW'(1)] = 1'b1;
      end else begin
         trial_s = trial_s;
      end

      if (dir_s == DIR_NONE) begin
         run_next_s = RW'(0);
      end else if (dir_s == last_q) begin
         run_next_s = (run_q == RUN_LIM) ? run_q : run_q + RW'(1);
      end else begin
         run_next_s = RW'(1);
      end

      if (!en) begin
         state_d  = ST_IDLE;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d  = ST_COARSE;
               ld_s     = 1'b1;
               ld_val_s = MID;
               bit_d    = BIT_TOP;
               settle_d = {SW{1'b0}};
            end
            ST_COARSE: begin
               if (!sample_vld) begin
                  state_d = ST_COARSE;
               end else if (settle_q < SETTLE_LIM) begin
                  settle_d = settle_q + SW'(1);
               end else begin
                  ld_s     = 1'b1;
                  ld_val_s = trial_s;
                  if (bit_q != {BW{1'b0}}) begin
                     bit_d    = bit_q - BW'(1);
                     settle_d = {SW{1'b0}};
                  end else begin
                     state_d = ST_FINE;
                     run_d   = {RW{1'b0}};
                     good_d  = {GW{1'b0}};
                     last_d  = DIR_NONE;
                  end
               end
            end
            ST_FINE, ST_LOCKED: begin
               if (!sample_vld) begin
                  state_d = state_q;
               end else begin
                  inc_s = (dir_s == DIR_UP);
                  dec_s = (dir_s == DIR_DN);
                  run_d = run_next_s;
                  if (dir_s != DIR_NONE) begin
                     last_d = dir_s;
                  end else begin
                     last_d = last_q;
                  end
                  if (run_next_s >= RUN_LIM) begin
                     // Runaway correction: throw the code away and search again.
                     state_d  = ST_COARSE;
                     locked_d = 1'b0;
                     ld_s     = 1'b1;
                     ld_val_s = MID;
                     bit_d    = BIT_TOP;
                     settle_d = {SW{1'b0}};
                     run_d    = {RW{1'b0}};
                     good_d   = {GW{1'b0}};
                     last_d   = DIR_NONE;
                  end else if (state_q == ST_FINE) begin
                     if (run_next_s <= RW'(1)) begin
                        good_next_s = (good_q == GOOD_LIM) ? good_q : good_q + GW'(1);
                     end else begin
                        good_next_s = {GW{1'b0}};
                     end
                     good_d = good_next_s;
                     if (good_next_s >= GOOD_LIM) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                     end else begin
                        state_d = ST_FINE;
                     end
                  end else begin
                     state_d = ST_LOCKED;
                  end
               end
            end
            default: begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   // Sequencer state and counters.
   always_ff @(posedge clk or negedge cdn) begin
      if (!cdn) begin
         state_q  <= ST_IDLE;
         last_q   <= DIR_NONE;
         bit_q    <= BIT_TOP;
         settle_q <= {SW{1'b0}};
         good_q   <= {GW{1'b0}};
         run_q    <= {RW{1'b0}};
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         bit_q    <= bit_d;
         settle_q <= settle_d;
         good_q   <= good_d;
         run_q    <= run_d;
         locked_q <= locked_d;
      end
   end

   dpll_sat_updn #(
      .W       (CODE_W),
      .RST_VAL (MID)
   ) u_code (
      .clk      (clk),
      .cdn      (cdn),
      .load     (ld_s),
      .load_val (ld_val_s),
      .inc      (inc_s),
      .dec      (dec_s),
      .q        (code_s)
   );

   assign dco_code = code_s;
   assign locked   = locked_q;
   assign state    = state_q;

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Scoreboard bench for dpll_lock_ctrl against a sample-history reference model.
module tb_dpll_lock_ctrl;

   localparam int CW = 8;
   localparam int ST = 2;
   localparam int LC = 4;
   localparam int UR = 3;

   logic       clk = 1'b0;
   logic       cdn = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       dn = 1'b0;
   logic       vld = 1'b0;
   logic [7:0] dco_code;
   logic       locked;
   logic [1:0] state;

   dpll_lock_ctrl #(
      .CODE_W     (CW),
      .SETTLE     (ST),
      .LOCK_CNT   (LC),
      .UNLOCK_RUN (UR)
   ) dut (
      .clk        (clk),
      .cdn        (cdn),
      .en         (en),
      .up         (up),
      .dn         (dn),
      .sample_vld (vld),
      .dco_code   (dco_code),
      .locked     (locked),
      .state      (state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int code;
      int lk;
      int st;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model: phase 0..3, code as an integer, acquisition sample count,
   // and the trailing run of equal corrections kept as a list.
   int m_st, m_code, m_lk, m_acq, m_good, target;
   int hist[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_code = 128; m_lk = 0; m_acq = 0; m_good = 0;
      hist.delete();
   endtask

   task automatic model_step(input int e, input int v, input int d);
      int pos, b, run;
      if (e == 0) begin
         m_st = 0; m_lk = 0;
      end else if (m_st == 0) begin
         m_st = 1; m_code = 128; m_acq = 0;
      end else if (m_st == 1) begin
         if (v != 0) begin
            pos = m_acq % (ST + 1);
            b   = CW - 1 - m_acq / (ST + 1);
            if (pos == ST) begin
               if (d == 2) m_code -= (1 << b);
               if (b > 0) m_code += (1 << (b - 1));
               else begin
                  m_st = 2; hist.delete(); m_good = 0;
               end
            end
            m_acq++;
         end
      end else if (v != 0) begin
         if (d == 1 && m_code < 255) m_code++;
         if (d == 2 && m_code > 0) m_code--;
         if (d == 0) hist.delete();
         else begin
            if (hist.size() > 0 && hist[$] != d) hist.delete();
            hist.push_back(d);
         end
         run = hist.size();
         if (run >= UR) begin
            m_st = 1; m_code = 128; m_acq = 0; m_lk = 0; hist.delete();
         end else if (m_st == 2) begin
            m_good = (run <= 1) ? m_good + 1 : 0;
            if (m_good >= LC) begin
               m_st = 3; m_lk = 1;
            end
         end
      end
   endtask

   task automatic step(input int e, input int v, input int u, input int d);
      exp_t x;
      int dir;
      @(negedge clk);
      en = e[0]; vld = v[0]; up = u[0]; dn = d[0];
      dir = (u != 0 && d == 0) ? 1 : ((d != 0 && u == 0) ? 2 : 0);
      model_step(e, v, dir);
      x.code = m_code; x.lk = m_lk; x.st = m_st;
      exp_q.push_back(x);
   endtask

   task automatic pfd_step(input int e, input int v);
      step(e, v, (m_code < target) ? 1 : 0, (m_code > target) ? 1 : 0);
   endtask

   task automatic acquire(input int tgt, input int n);
      int got;
      target = tgt;
      got = 0;
      while (got < n) begin
         int v;
         v = ($urandom_range(0, 3) != 0) ? 1 : 0;
         pfd_step(1, v);
         got += v;
      end
   endtask

   task automatic dchk(input string nm, input int code, input int lk, input int st);
      @(posedge clk);
      #2;
      chk({nm, "_code"}, dco_code, code);
      chk({nm, "_locked"}, locked, lk);
      chk({nm, "_state"}, state, st);
   endtask

   task automatic pulse_reset(input string nm);
      @(posedge clk);
      #2 cdn = 1'b0;
      #1;
      chk({nm, "_code"}, dco_code, 8'h80);
      chk({nm, "_locked"}, locked, 0);
      chk({nm, "_state"}, state, 0);
      #1 cdn = 1'b1;
      model_reset();
   endtask

   // Monitor: one expectation per clock, compared just after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("sb_code", dco_code, mon_e.code);
         chk("sb_locked", locked, mon_e.lk);
         chk("sb_state", state, mon_e.st);
      end
   end

   initial begin
      int mode;
      model_reset();
      #7 cdn = 1'b1;
      pulse_reset("rst");

      step(1, 0, 0, 0);
      acquire(8'h5A, 24);
      dchk("acq5a", 8'h5A, 0, 2);

      step(1, 1, 1, 0); step(1, 1, 0, 1); step(1, 1, 1, 0); step(1, 1, 0, 1);
      dchk("lock", 8'h5A, 1, 3);

      step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
      dchk("unlock", 8'h80, 0, 1);

      acquire(8'hFF, 24);
      step(1, 1, 1, 0); step(1, 1, 1, 0);
      dchk("satff", 8'hFF, 0, 2);
      step(1, 1, 1, 0);
      dchk("runff", 8'h80, 0, 1);

      acquire(8'h00, 24);
      step(1, 1, 0, 1); step(1, 1, 0, 1);
      dchk("sat00", 8'h00, 0, 2);
      step(1, 1, 0, 1);
      dchk("run00", 8'h80, 0, 1);

      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      target = 8'h5A;
      for (int i = 0; i < 7; i++) pfd_step(1, 1);
      step(0, 1, 1, 0);
      dchk("enoff", 8'h60, 0, 0);
      step(1, 0, 0, 0);
      dchk("enon", 8'h80, 0, 1);
      acquire(8'h5A, 24);
      dchk("reacq", 8'h5A, 0, 2);

      mode = 0;
      for (int i = 0; i < 4000; i++) begin
         int e, v, u, d;
         if (i % 200 == 0) begin
            mode = $urandom_range(0, 2);
            target = $urandom_range(0, 255);
         end
         if ($urandom_range(0, 999) < 2) pulse_reset("rnd_rst");
         e = ($urandom_range(0, 99) >= 3) ? 1 : 0;
         v = ($urandom_range(0, 9) < 7) ? 1 : 0;
         if (mode == 1) begin
            u = $urandom_range(0, 1);
            d = $urandom_range(0, 1);
         end else begin
            u = (m_code < target) ? 1 : 0;
            d = (m_code > target) ? 1 : 0;
            if (mode == 2 && $urandom_range(0, 4) == 0) begin
               u = $urandom_range(0, 1);
               d = $urandom_range(0, 1);
            end
         end
         step(e, v, u, d);
      end

      repeat (3) @(posedge clk);
      #2;
      chk("drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
